// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter shared definitions: FSM states, default geometry, core index type.
package dm_arb_pkg;

    localparam int NCORES_DEF = 4;
    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 8;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef logic [$clog2(NCORES_DEF)-1:0] core_idx_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Core request/grant/read-return channels plus the single-port memory bus.
// master = cores and memory (the environment), slave = the arbiter.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    gnt;
    logic [NCORES-1:0]    rvalid;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_wren;
    logic [DW-1:0]        mem_q;

    modport master (
        output req, we, addr, wdata, mem_q,
        input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  req, we, addr, wdata, mem_q,
        output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/dm_arbiter_rr_picker.sv
// Round-robin find-first-set: first requesting core at or above ptr, wrapping.
module rr_picker #(
    parameter int NCORES = 4,
    parameter int IW     = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic              found,
    output logic [IW-1:0]     idx
);
    logic [NCORES-1:0] req_rot;
    logic [IW-1:0]     off;
    logic [IW:0]       sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot = NCORES'({req, req} >> ptr);
        off     = '0;
        for (int o = NCORES - 1; o >= 0; o--) begin
            if (req_rot[o]) begin
                off = IW'(o);
            end
        end
        found = |req_rot;
        sum   = {1'b0, ptr} + {1'b0, off};
        idx   = (sum >= (IW+1)'(NCORES)) ? IW'(sum - (IW+1)'(NCORES)) : IW'(sum);
    end
endmodule

// File: rtl/dm_arbiter.sv
// Time-multiplexes one single-port data memory (1-cycle read latency) between
// NCORES cores. IDLE arbitrates, ACCESS drives the memory, RESP returns read data.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic             clock,
    input  logic             rst_r,
    dm_arbiter_if.slave      bus,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);
    localparam int IW = $clog2(NCORES);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [NCORES-1:0] gnt_q, gnt_d;
    logic [NCORES-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              mem_wren_q, mem_wren_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    logic [AW-1:0]     addr_lane  [NCORES];
    logic [DW-1:0]     wdata_lane [NCORES];

    for (genvar gi = 0; gi < NCORES; gi++) begin : g_lane
        assign addr_lane[gi]  = bus.addr[gi*AW +: AW];
        assign wdata_lane[gi] = bus.wdata[gi*DW +: DW];
    end

    rr_picker #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and registered-output values. Requests are looked at only in
    // IDLE, so a core can hold req high across its grant to chain accesses.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        widx_d      = widx_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        txn_count_d = txn_count_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    widx_d      = pick_idx;
                    mem_addr_d  = addr_lane[pick_idx];
                    mem_wdata_d = wdata_lane[pick_idx];
                    mem_wren_d  = bus.we[pick_idx];
                    gnt_d       = NCORES'(1) << pick_idx;
                    ptr_d       = (pick_idx == IW'(NCORES - 1)) ? '0 : pick_idx + IW'(1);
                    txn_count_d = txn_count_q + CNT_W'(1);
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // mem_wren_q still holds the latched write enable here.
                state_d = mem_wren_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                rdata_d  = bus.mem_q;
                rvalid_d = NCORES'(1) << widx_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears everything at once, aborting
    // any write strobe and dropping an in-flight read.
    always_ff @(posedge clock or negedge rst_r) begin
        if (!rst_r) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            widx_q      <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            busy_q      <= 1'b0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            widx_q      <= widx_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            busy_q      <= busy_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wren  = mem_wren_q;
    assign busy          = busy_q;
    assign txn_count     = txn_count_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: expected grants/read returns are queued when
// requests are driven and popped when the arbiter pulses gnt/rvalid.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int NC = 4;

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          cyc;
        logic [15:0] cnt;
    } gexp_t;

    typedef struct {
        int         core;
        logic [7:0] data;
        int         cyc;
    } rexp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] txn_count;

    int          total      = 0;
    int          bad        = 0;
    int          cyc        = 0;
    int          wren_seen  = 0;
    int          wr_pushed  = 0;
    logic [15:0] cnt_model  = 16'd0;
    logic [7:0]  last_rdata = 8'd0;

    logic [7:0]  phys_mem [65536];
    logic [7:0]  ref_mem  [65536];
    int          rem      [NC];
    gexp_t       gq [$];
    rexp_t       rq [$];
    gexp_t       g_mon;
    rexp_t       r_mon;

    dm_arbiter_if #(.NCORES(NC), .AW(16), .DW(8)) bus ();

    dm_arbiter #(.NCORES(NC), .AW(16), .DW(8)) dut (
        .clock     (clk),
        .rst_r     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with registered read.
    always @(posedge clk) begin
        if (bus.mem_wren) phys_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= phys_mem[bus.mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check_val({tag, "_gnt"},       32'(bus.gnt),       0);
        check_val({tag, "_rvalid"},    32'(bus.rvalid),    0);
        check_val({tag, "_rdata"},     32'(bus.rdata),     0);
        check_val({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
        check_val({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check_val({tag, "_mem_wren"},  32'(bus.mem_wren),  0);
        check_val({tag, "_busy"},      32'(busy),          0);
        check_val({tag, "_txn_count"}, 32'(txn_count),     0);
    endtask

    // Queue the expected grant (and read return, unless it will be dropped).
    task automatic exp_txn(input int core, input logic w, input logic [15:0] a,
                           input logic [7:0] d, input int gcyc, input bit keep_rv);
        gexp_t g;
        rexp_t r;
        cnt_model = cnt_model + 16'd1;
        g.core = core; g.we = w; g.addr = a; g.wdata = d; g.cyc = gcyc; g.cnt = cnt_model;
        gq.push_back(g);
        if (w) begin
            ref_mem[a] = d;
            wr_pushed++;
        end else if (keep_rv) begin
            r.core = core; r.data = ref_mem[a]; r.cyc = gcyc + 2;
            rq.push_back(r);
            last_rdata = ref_mem[a];
        end
    endtask

    task automatic issue(input int core, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input int n);
        bus.we[core]            = w;
        bus.addr[core*16 +: 16] = a;
        bus.wdata[core*8 +: 8]  = d;
        bus.req[core]           = 1'b1;
        rem[core]               = n;
    endtask

    // Drop each core's req after its last wanted grant; stop when all expected
    // traffic has been observed, or flag a timeout.
    task automatic run_idle(input int budget);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NC; i++) begin
                if (bus.gnt[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) bus.req[i] = 1'b0;
                end
            end
            if (bus.req == '0 && gq.size() == 0 && rq.size() == 0) break;
            n++;
            if (n >= budget) begin
                check_val("timeout", 1, 0);
                bus.req = '0;
                gq.delete();
                rq.delete();
                break;
            end
        end
    endtask

    // Monitor: compare every grant / read return against the scoreboard.
    always @(negedge clk) begin
        if (bus.gnt != '0) begin
            if (gq.size() == 0) begin
                check_val("gnt_unexpected", 32'(bus.gnt), 0);
            end else begin
                g_mon = gq.pop_front();
                $display("grant core=%0d we=%0d addr=%h wdata=%h cyc=%0d cnt=%h",
                         g_mon.core, g_mon.we, g_mon.addr, g_mon.wdata, cyc, txn_count);
                check_val("gnt_core",  32'(bus.gnt), 32'd1 << g_mon.core);
                check_val("gnt_cycle", cyc, g_mon.cyc);
                check_val("mem_addr",  32'(bus.mem_addr), 32'(g_mon.addr));
                check_val("mem_wren",  32'(bus.mem_wren), 32'(g_mon.we));
                if (g_mon.we) check_val("mem_wdata", 32'(bus.mem_wdata), 32'(g_mon.wdata));
                check_val("txn_count", 32'(txn_count), 32'(g_mon.cnt));
                check_val("busy_access", 32'(busy), 1);
            end
        end
        if (bus.mem_wren) begin
            wren_seen++;
            check_val("wren_without_gnt", 32'(bus.gnt != '0), 1);
        end
        if (bus.rvalid != '0) begin
            if (rq.size() == 0) begin
                check_val("rvalid_unexpected", 32'(bus.rvalid), 0);
            end else begin
                r_mon = rq.pop_front();
                $display("rdata core=%0d data=%h cyc=%0d", r_mon.core, bus.rdata, cyc);
                check_val("rvalid_core",  32'(bus.rvalid), 32'd1 << r_mon.core);
                check_val("rdata",        32'(bus.rdata), 32'(r_mon.data));
                check_val("rvalid_cycle", cyc, r_mon.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 65536; i++) begin
            phys_mem[i] = 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end
        phys_mem[16'h0040] = 8'hA5;
        ref_mem[16'h0040]  = 8'hA5;
        for (int i = 0; i < NC; i++) rem[i] = 0;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single read: core 2 reads 0x0040.
        @(posedge clk); #1;
        exp_txn(2, 1'b0, 16'h0040, 8'h00, cyc + 1, 1'b1);
        issue(2, 1'b0, 16'h0040, 8'h00, 1);
        run_idle(40);
        check_val("read_a5", 32'(bus.rdata), 32'h00A5);
        check_val("busy_idle", 32'(busy), 0);

        // Write 0x3C to 0x0010 from core 1, then read it back.
        @(posedge clk); #1;
        exp_txn(1, 1'b1, 16'h0010, 8'h3C, cyc + 1, 1'b1);
        issue(1, 1'b1, 16'h0010, 8'h3C, 1);
        run_idle(40);
        check_val("rdata_hold", 32'(bus.rdata), 32'(last_rdata));
        check_val("mem_written", 32'(phys_mem[16'h0010]), 32'h003C);
        @(posedge clk); #1;
        exp_txn(1, 1'b0, 16'h0010, 8'h00, cyc + 1, 1'b1);
        issue(1, 1'b0, 16'h0010, 8'h00, 1);
        run_idle(40);

        // Pointer skip: last grant was core 1, now cores 0 and 3 -> 3 first.
        @(posedge clk); #1;
        k = cyc;
        exp_txn(3, 1'b0, 16'h0123, 8'h00, k + 1, 1'b1);
        exp_txn(0, 1'b0, 16'h0200, 8'h00, k + 4, 1'b1);
        issue(3, 1'b0, 16'h0123, 8'h00, 1);
        issue(0, 1'b0, 16'h0200, 8'h00, 1);
        run_idle(60);

        // Contention from reset: all four read continuously -> 0,1,2,3,0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n      = 1'b1;
        cnt_model  = 16'd0;
        last_rdata = 8'd0;
        @(posedge clk); #1;
        k = cyc;
        for (int i = 0; i < NC; i++)
            exp_txn(i, 1'b0, 16'(16'h0300 + i), 8'h00, k + 1 + 3 * i, 1'b1);
        exp_txn(0, 1'b0, 16'h0300, 8'h00, k + 13, 1'b1);
        issue(0, 1'b0, 16'h0300, 8'h00, 2);
        for (int i = 1; i < NC; i++)
            issue(i, 1'b0, 16'(16'h0300 + i), 8'h00, 1);
        run_idle(80);

        // Reset during RESP of a core-1 read: read dropped, outputs cleared at once.
        @(posedge clk); #1;
        k = cyc;
        exp_txn(1, 1'b0, 16'h0077, 8'h00, k + 1, 1'b0);
        issue(1, 1'b0, 16'h0077, 8'h00, 1);
        @(posedge clk); #1;
        bus.req = '0;
        rem[1]  = 0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outs_zero("async_reset");
        @(posedge clk); #1;
        rst_n      = 1'b1;
        cnt_model  = 16'd0;
        last_rdata = 8'd0;
        check_val("gq_after_abort", gq.size(), 0);

        // After reset the pointer is back at 0: cores 0 and 2 -> 0 first.
        @(posedge clk); #1;
        k = cyc;
        exp_txn(0, 1'b0, 16'h0400, 8'h00, k + 1, 1'b1);
        exp_txn(2, 1'b0, 16'h0402, 8'h00, k + 4, 1'b1);
        issue(0, 1'b0, 16'h0400, 8'h00, 1);
        issue(2, 1'b0, 16'h0402, 8'h00, 1);
        run_idle(60);

        // Counter wrap: preload 0xFFFE, then two writes -> 0xFFFF, 0x0000.
        @(posedge clk); #1;
        force dut.txn_count_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.txn_count_q;
        cnt_model = 16'hFFFE;
        @(posedge clk); #1;
        exp_txn(3, 1'b1, 16'h0500, 8'h11, cyc + 1, 1'b1);
        issue(3, 1'b1, 16'h0500, 8'h11, 1);
        run_idle(40);
        check_val("cnt_ffff", 32'(txn_count), 32'h0000FFFF);
        @(posedge clk); #1;
        exp_txn(3, 1'b1, 16'h0501, 8'h22, cyc + 1, 1'b1);
        issue(3, 1'b1, 16'h0501, 8'h22, 1);
        run_idle(40);
        check_val("cnt_wrap", 32'(txn_count), 0);

        repeat (3) @(posedge clk);
        #1;
        check_val("gnt_queue_left", gq.size(), 0);
        check_val("rv_queue_left", rq.size(), 0);
        check_val("wren_pulses", wren_seen, wr_pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shared data-memory arbiter for the quad-core machine. It time-multiplexes one single-port data memory between `NCORES` processor cores, so each core can issue independent addresses instead of all cores slaving to one address bus. Each core has its own request/grant/read-return channel. The memory side connects directly to the existing data memory, which has a one-cycle read latency.

## Interface
- `NCORES`, default 4: number of requesting cores.
- `AW`, default 16: memory address width.
- `DW`, default 8: data width per access.
- `clock`  in  1: system clock (divided clock); all state updates on rising edge.
- `rst_r`  in  1: reset, asynchronous, active-low.
- `req`  in  NCORES: per-core access request; held high until the matching `gnt` pulse.
- `we`  in  NCORES: per-core write enable, qualified by `req`.
- `addr`  in  NCORES*AW: packed per-core addresses; core i occupies `[i*AW +: AW]`.
- `wdata`  in  NCORES*DW: packed per-core write data; core i occupies `[i*DW +: DW]`.
- `gnt`  out  NCORES: one-hot, one-cycle pulse; the request is consumed.
- `rvalid`  out  NCORES: one-hot, one-cycle pulse; `rdata` is valid for that core.
- `rdata`  out  DW: read data, shared by all cores and qualified by `rvalid`.
- `mem_addr`  out  AW: memory address.
- `mem_wdata`  out  DW: memory write data.
- `mem_wren`  out  1: memory write strobe.
- `mem_q`  in  DW: memory read data; valid in the cycle after `mem_addr` is presented.
- `busy`  out  1: high in every state except IDLE.
- `txn_count`  out  16: count of completed grants; wraps from 0xFFFF to 0.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- **IDLE:**
  - If any `req` bit is high, pick a winner w by round-robin: the first set bit searching upward from `ptr`, modulo NCORES.
  - Latch `addr[w]`, `wdata[w]` and `we[w]` into the `mem_*` registers and set `gnt` to one-hot(w).
  - Go to ACCESS.
  - If no request is pending, stay in IDLE.
- **ACCESS:**
  - `gnt[w]` is high and `mem_wren` is high if the latched `we` was set.
  - `ptr` is updated to (w+1) mod NCORES.
  - `txn_count` increments.
  - On a write, go to IDLE. On a read, go to RESP.
- **RESP:**
  - `mem_q` is valid in this cycle.
  - Register `mem_q` into `rdata` and set `rvalid` to one-hot(w).
  - Go to IDLE.
- In the cycle `gnt[i]` is high, the arbiter never samples `req[i]`. Arbitration occurs only in IDLE, so a core may keep `req` high to chain its next access.
- `rdata` holds its last value between reads.
- Arbitration fairness: with all cores requesting continuously, grants rotate 0,1,2,3,0,… No core waits more than NCORES−1 foreign transactions.
- Reset (asynchronous, any state):
  - State returns to IDLE and `ptr` to 0.
  - All outputs are cleared immediately: `mem_addr`, `mem_wdata`, `mem_wren`, `gnt`, `rvalid`, `rdata`, `busy` and `txn_count` all go to 0.
  - An in-flight read is dropped with no `rvalid`.
  - A write in ACCESS is aborted because `mem_wren` is cleared asynchronously.

## Timing
- Request seen in IDLE at cycle 0:
  - Cycle 1 is ACCESS, with `gnt` high and `mem_addr`/`mem_wren` driven.
  - For a read, cycle 2 is RESP and `rvalid`/`rdata` are visible in cycle 3.
- Throughput: a write takes 2 cycles (IDLE+ACCESS) and a read takes 3 cycles.
- All outputs are registered. There is no combinational path from `req` to any output.
- `mem_wren` is high for exactly one cycle per write.
- The latched address and data are stable for the whole transaction, even if the requester changes its `addr` after `gnt`.

## Structure
- Package `dm_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the default constants for NCORES, AW and DW;
  - a `core_idx_t` typedef of width $clog2(NCORES).
- Sub-module `rr_picker`: a combinational find-first-set from a rotating pointer.
  - Inputs: `req` and `ptr`.
  - Outputs: `found` and `idx`.
  - It is instantiated once. The rest of the FSM, registers and counter stay in `dm_arbiter`.

## Test plan
- Single read: memory[0x0040] preloaded to 0xA5; core 2 reads addr 0x0040 at cycle 0 -> `gnt`=0100 in cycle 1, then `rvalid`=0100 and `rdata`=0xA5 in cycle 3, `txn_count`=1.
- Single write then read-back: core 1 writes 0x3C to 0x0010, then reads 0x0010 -> `mem_wren` pulses once with `mem_addr`=0x0010 and `mem_wdata`=0x3C, and the read returns 0x3C.
- Contention: all four `req` high continuously (reads) from reset -> grant order 0,1,2,3,0 and each `rvalid` lands 2 cycles after its `gnt`.
- Skipping the pointer: after core 1 is granted, only cores 0 and 3 request -> core 3 is granted before core 0.
- Reset mid-read: assert `rst_r` low during RESP -> no `rvalid`, all outputs 0 asynchronously, and after release the next grant goes to core 0.
- Counter wrap: preload via 65535 writes, then one more -> `txn_count` goes from 0xFFFF to 0x0000.
